mem_stage: RTL

- Memory-access pipeline stage plus MEM/WB pipeline register.
- Takes EX/MEM results, performs 64-bit data-memory loads and stores over a req/ack interface, and presents registered register number, loaded data, ALU result, MemToReg and RegWrite to the write-back stage.
- Stalls upstream while an access is outstanding.
- Aborts accesses that are misaligned or that time out.

---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register: 64-bit loads/stores over a
// req/ack port, upstream stall while outstanding, abort on misalignment or timeout.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [63:0] wb_loaded_data,
  output logic [63:0] wb_results,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic        mem_fault
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [63:0] dmem_addr_q, dmem_addr_d;
  logic [63:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [63:0] wb_loaded_data_q, wb_loaded_data_d;
  logic [63:0] wb_results_q, wb_results_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        mem_fault_q, mem_fault_d;
  logic        mem_op_s, bad_s, stall_s;

  assign mem_op_s = ex_valid & (ex_mem_read | ex_mem_write);
  assign bad_s    = mem_op_s & ((ex_alu_result[2:0] != 3'd0) | (ex_mem_read & ex_mem_write));

  // Next-state, request and write-back register computation
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    wb_valid_d       = wb_valid_q;
    wb_reg_d         = wb_reg_q;
    wb_loaded_data_d = wb_loaded_data_q;
    wb_results_d     = wb_results_q;
    wb_mem_to_reg_d  = wb_mem_to_reg_q;
    wb_reg_write_d   = wb_reg_write_q;
    mem_fault_d      = 1'b0;
    stall_s          = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s && !bad_s) begin
          stall_s      = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = ex_mem_write;
          dmem_addr_d  = ex_alu_result;
          dmem_wdata_d = ex_store_data;
          cnt_d        = 8'd0;
          state_d      = ACCESS;
          wb_valid_d   = 1'b0;
        end else begin
          wb_valid_d       = ex_valid;
          wb_reg_d         = ex_rd;
          wb_results_d     = ex_alu_result;
          wb_mem_to_reg_d  = ex_mem_to_reg;
          wb_loaded_data_d = 64'd0;
          wb_reg_write_d   = ex_reg_write & ~bad_s;
          mem_fault_d      = bad_s;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // The instruction is still held on ex_* since it was stalled.
          wb_valid_d       = 1'b1;
          wb_reg_d         = ex_rd;
          wb_results_d     = ex_alu_result;
          wb_mem_to_reg_d  = ex_mem_to_reg;
          wb_reg_write_d   = ex_reg_write;
          wb_loaded_data_d = dmem_we_q ? 64'd0 : dmem_rdata;
          dmem_req_d       = 1'b0;
          state_d          = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d       = 1'b1;
          wb_reg_d         = ex_rd;
          wb_results_d     = ex_alu_result;
          wb_mem_to_reg_d  = ex_mem_to_reg;
          wb_reg_write_d   = 1'b0;
          wb_loaded_data_d = 64'd0;
          mem_fault_d      = 1'b1;
          dmem_req_d       = 1'b0;
          state_d          = IDLE;
        end else begin
          stall_s    = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
    if (reset) begin
      mem_stall = 1'b0;
    end else begin
      mem_stall = stall_s;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= 8'd0;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= 64'd0;
      dmem_wdata_q     <= 64'd0;
      wb_valid_q       <= 1'b0;
      wb_reg_q         <= 5'd0;
      wb_loaded_data_q <= 64'd0;
      wb_results_q     <= 64'd0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      mem_fault_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_q         <= wb_reg_d;
      wb_loaded_data_q <= wb_loaded_data_d;
      wb_results_q     <= wb_results_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_reg_write_q   <= wb_reg_write_d;
      mem_fault_q      <= mem_fault_d;
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg         = wb_reg_q;
  assign wb_loaded_data = wb_loaded_data_q;
  assign wb_results     = wb_results_q;
  assign wb_mem_to_reg  = wb_mem_to_reg_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign mem_fault      = mem_fault_q;

endmodule
